// File: rtl/cgp_fitness_eval.sv
// ============================================================================
// Module : cgp_fitness_eval
// Brief  : Exhaustive truth-table fitness evaluator wrapped around cgp_module.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cgp_fitness_eval #(
  parameter int N_IN          = 10,
  parameter int N_OUT         = 10,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  exp_addr,
  input  logic [N_OUT-1:0] exp_data,
  output logic [FIT_W-1:0] fitness,
  output logic             perfect
);

  localparam int          PC_W     = $clog2(N_OUT + 1);
  localparam int          SC_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [N_IN:0] LAST_VEC = {1'b0, {N_IN{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_COMPARE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t           state_q;
  logic [N_IN:0]    vec_q;
  logic [SC_W-1:0]  settle_q;
  logic             busy_q;
  logic             done_q;
  logic             perfect_q;
  logic [N_IN-1:0]  dut_in_q;
  logic [N_IN-1:0]  exp_addr_q;
  logic [FIT_W-1:0] fitness_q;
  logic [FIT_W-1:0] fitness_d;
  logic [PC_W-1:0]  popcnt;
  logic [N_OUT-1:0] mismatch;
  logic [FIT_W:0]   fit_sum;

  // Mismatch weight of the current vector, added with saturation.
  always_comb begin
    mismatch = dut_out ^ exp_data;
    popcnt   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      popcnt = popcnt + PC_W'(mismatch[i]);
    end
    fit_sum   = {1'b0, fitness_q} + (FIT_W + 1)'(popcnt);
    fitness_d = fit_sum[FIT_W] ? {FIT_W{1'b1}} : fit_sum[FIT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      perfect_q  <= 1'b0;
      dut_in_q   <= '0;
      exp_addr_q <= '0;
      fitness_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_APPLY;
            vec_q     <= '0;
            busy_q    <= 1'b1;
            perfect_q <= 1'b0;
          end
        end
        S_APPLY: begin
          dut_in_q   <= vec_q[N_IN-1:0];
          exp_addr_q <= vec_q[N_IN-1:0];
          settle_q   <= SC_W'(SETTLE_CYCLES);
          // Previous result stays visible until the new sweep really begins.
          if (vec_q == '0) begin
            fitness_q <= '0;
          end
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_q <= settle_q - 1'b1;
          if (settle_q == SC_W'(1)) begin
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          fitness_q <= fitness_d;
          if (vec_q == LAST_VEC) begin
            state_q   <= S_FINISH;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            perfect_q <= (fitness_d == '0);
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign perfect  = perfect_q;
  assign dut_in   = dut_in_q;
  assign exp_addr = exp_addr_q;
  assign fitness  = fitness_q;

endmodule

`default_nettype wire
